// File: rtl/hpi_io_sequencer.sv
// Conditions the NIOS HPI PIO exports into fixed-width CY7C67200 host-port strobes and owns the data-bus tristate.
// Latency: strobe falls on the 4th clock edge after a PIO request edge; one access occupies 9 clocks (busy high).
// No backpressure: requests arriving while busy are dropped, so software must watch busy and re-toggle the PIO.
module hpi_io_sequencer #(
    parameter int STROBE_CYCLES   = 4,
    parameter int RECOVERY_CYCLES = 3,
    parameter int RESET_CYCLES    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  from_sw_addr,
    input  logic [15:0] from_sw_data_out,
    input  logic        from_sw_cs_n,
    input  logic        from_sw_r_n,
    input  logic        from_sw_w_n,
    input  logic        from_sw_reset_n,
    output logic [15:0] to_sw_data_in,
    output logic        busy,
    inout  wire  [15:0] otg_data,
    output logic [1:0]  otg_addr,
    output logic        otg_cs_n,
    output logic        otg_rd_n,
    output logic        otg_wr_n,
    output logic        otg_rst_n
);

    localparam int MAX_SR  = (STROBE_CYCLES > RECOVERY_CYCLES) ? STROBE_CYCLES : RECOVERY_CYCLES;
    localparam int CNT_MAX = (MAX_SR > RESET_CYCLES) ? MAX_SR : RESET_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] STROBE_LAST  = CNT_W'(STROBE_CYCLES);
    localparam logic [CNT_W-1:0] RECOVER_LAST = CNT_W'(RECOVERY_CYCLES);
    localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(RESET_CYCLES);
    localparam logic [CNT_W-1:0] CNT_SAT      = '1;
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        RECOVER,
        RST
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_inc;

    logic [1:0]        s_addr;
    logic [15:0]       s_data;
    logic              s_cs_n;
    logic              s_r_n;
    logic              s_w_n;
    logic              s_reset_n;
    logic              s_r_n_q;
    logic              s_w_n_q;

    logic              rd_fall;
    logic              wr_fall;
    logic              req_vld;
    logic              req_wr;

    logic              lat_wr;
    logic [15:0]       wr_dat;
    logic              drive_en;

    assign rd_fall  = s_r_n_q & ~s_r_n & ~s_cs_n;
    assign wr_fall  = s_w_n_q & ~s_w_n & ~s_cs_n;
    assign cnt_inc  = (cnt == CNT_SAT) ? cnt : cnt + 1'b1;
    assign otg_data = drive_en ? wr_dat : 16'hzzzz;

    always_ff @(posedge clk) begin
        if (reset) begin
            s_addr        <= 2'd0;
            s_data        <= 16'h0000;
            s_cs_n        <= 1'b1;
            s_r_n         <= 1'b1;
            s_w_n         <= 1'b1;
            s_reset_n     <= 1'b1;
            s_r_n_q       <= 1'b1;
            s_w_n_q       <= 1'b1;
            req_vld       <= 1'b0;
            req_wr        <= 1'b0;
            state         <= IDLE;
            cnt           <= '0;
            lat_wr        <= 1'b0;
            wr_dat        <= 16'h0000;
            drive_en      <= 1'b0;
            to_sw_data_in <= 16'h0000;
            busy          <= 1'b0;
            otg_addr      <= 2'd0;
            otg_cs_n      <= 1'b1;
            otg_rd_n      <= 1'b1;
            otg_wr_n      <= 1'b1;
            otg_rst_n     <= 1'b1;
        end else begin
            s_addr    <= from_sw_addr;
            s_data    <= from_sw_data_out;
            s_cs_n    <= from_sw_cs_n;
            s_r_n     <= from_sw_r_n;
            s_w_n     <= from_sw_w_n;
            s_reset_n <= from_sw_reset_n;
            s_r_n_q   <= s_r_n;
            s_w_n_q   <= s_w_n;
            // Write wins a tie; the request is a one-clock pulse, so it is lost unless IDLE sees it.
            req_vld   <= wr_fall | rd_fall;
            req_wr    <= wr_fall;

            case (state)
                IDLE: begin
                    otg_cs_n <= s_cs_n;
                    if (!s_reset_n) begin
                        state     <= RST;
                        cnt       <= CNT_ONE;
                        busy      <= 1'b1;
                        otg_cs_n  <= 1'b1;
                        otg_rst_n <= 1'b0;
                    end else if (req_vld) begin
                        state    <= SETUP;
                        busy     <= 1'b1;
                        lat_wr   <= req_wr;
                        wr_dat   <= s_data;
                        drive_en <= req_wr;
                        otg_addr <= s_addr;
                        otg_cs_n <= 1'b0;
                    end
                end
                SETUP: begin
                    state <= STROBE;
                    cnt   <= CNT_ONE;
                    if (lat_wr) begin
                        otg_wr_n <= 1'b0;
                    end else begin
                        otg_rd_n <= 1'b0;
                    end
                end
                STROBE: begin
                    if (cnt >= STROBE_LAST) begin
                        state    <= HOLD;
                        otg_rd_n <= 1'b1;
                        otg_wr_n <= 1'b1;
                        if (!lat_wr) begin
                            to_sw_data_in <= otg_data;
                        end
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                HOLD: begin
                    state    <= RECOVER;
                    cnt      <= CNT_ONE;
                    drive_en <= 1'b0;
                    otg_cs_n <= 1'b1;
                end
                RECOVER: begin
                    if (cnt >= RECOVER_LAST) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        otg_cs_n <= s_cs_n;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                RST: begin
                    // Minimum pulse width first, then wait for software to let go of reset_n.
                    if (cnt >= RESET_LAST && s_reset_n) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        otg_rst_n <= 1'b1;
                        otg_cs_n  <= s_cs_n;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    drive_en  <= 1'b0;
                    otg_cs_n  <= 1'b1;
                    otg_rd_n  <= 1'b1;
                    otg_wr_n  <= 1'b1;
                    otg_rst_n <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/hpi_io_sequencer.md
Name: hpi_io_sequencer

Overview:
- Sits between the SoC's HPI PIO exports and the CY7C67200 host-port pins. It conditions the host-port interface for the pins.
- It registers the software-driven PIO levels and turns each software read or write request into exactly one strobe of fixed width on the pins.
- It owns the tristate control of the 16-bit data bus and captures read data into a register that feeds the hpi_data_in PIO.
- It guarantees chip timing (strobe width, recovery, reset pulse width) no matter how fast the NIOS toggles the PIOs.

Parameters:
- STROBE_CYCLES, 4: clocks that RD_N or WR_N is held low per access (at 50 MHz, 80 ns).
- RECOVERY_CYCLES, 3: clocks of strobes-high before another access may start.
- RESET_CYCLES, 16: minimum clocks otg_rst_n is held low per reset request.

Ports:
- clk, in, 1: system clock (sdram_clk_50 domain).
- reset, in, 1: synchronous active-high reset.
- from_sw_addr, in, 2: hpi_addr_export.
- from_sw_data_out, in, 16: hpi_data_out_port (write data).
- from_sw_cs_n, in, 1: hpi_cs_export, active low.
- from_sw_r_n, in, 1: hpi_r_export, active low.
- from_sw_w_n, in, 1: hpi_w_export, active low.
- from_sw_reset_n, in, 1: hpi_reset_export, active low.
- to_sw_data_in, out, 16: to hpi_data_in_port; last captured read data.
- busy, out, 1: high while an access or reset pulse is in progress.
- otg_data, inout, 16: chip data bus.
- otg_addr, out, 2: chip address.
- otg_cs_n, out, 1: chip select.
- otg_rd_n, out, 1: chip read strobe.
- otg_wr_n, out, 1: chip write strobe.
- otg_rst_n, out, 1: chip reset.

Behaviour:
- All inputs are registered once (stage S). Requests are detected against the previous value of stage S.
- Reset values:
  - otg_cs_n, otg_rd_n, otg_wr_n = 1; otg_rst_n = 1; otg_addr = 0.
  - to_sw_data_in = 0; busy = 0; data bus released (Z); FSM in IDLE.
- Read request: falling edge of S.r_n while S.cs_n = 0.
- Write request: falling edge of S.w_n while S.cs_n = 0.
- Simultaneous read and write edges: write wins, and the read edge is discarded.
- FSM states: IDLE, SETUP, STROBE, HOLD, RECOVER, RST.
- IDLE:
  - If S.reset_n = 0: go to RST.
  - Else on a request: latch addr, write data and direction, then go to SETUP.
  - Else stay.
  - otg_cs_n follows S.cs_n in IDLE.
- SETUP (1 clock):
  - otg_addr = latched addr, otg_cs_n = 0.
  - For a write, drive otg_data from this clock.
  - Go to STROBE.
- STROBE (STROBE_CYCLES clocks): the selected strobe is low.
  - Read: on the last STROBE clock, to_sw_data_in <= otg_data.
- HOLD (1 clock):
  - Strobe high; cs_n stays low; write data is still driven.
  - Then release the bus and go to RECOVER.
- RECOVER (RECOVERY_CYCLES clocks): strobes high, bus Z, then go to IDLE.
- Latency from request to strobe: PIO change → register S (1) → edge detect/IDLE (1) → SETUP (1) → strobe low on the 4th clock edge.
- busy = 1 in every state except IDLE.
- Requests seen while not in IDLE are dropped. No queueing. Software must hold or re-toggle the PIO.
- RST state:
  - otg_rst_n = 0 for at least RESET_CYCLES clocks.
  - Exit when the count is done AND S.reset_n = 1.
  - otg_rst_n is 1 again on the exit clock.
  - Then go to IDLE.
- Reset mid-access: no abort on S.reset_n. A chip reset request is honoured only from IDLE; a held request starts after RECOVER finishes.
- Synchronous reset mid-access: immediately return all outputs to reset values. The bus releases in the same clock.
- Data-bus rule: the block drives otg_data only in SETUP, STROBE and HOLD of a write. It never drives during a read, so there is no contention.
- Counter width: clog2(max(STROBE_CYCLES, RECOVERY_CYCLES, RESET_CYCLES)) + 1. The counter saturates and never wraps.
- to_sw_data_in changes only on a read capture or on reset.

Test Plan:
- Reset then idle: assert reset 2 clocks → cs_n/rd_n/wr_n/rst_n = 1, otg_data = Z, to_sw_data_in = 0x0000, busy = 0.
- Write: cs_n = 0, addr = 2, data_out = 0xBEEF, w_n falls → otg_addr = 2; otg_wr_n low for exactly 4 clocks; otg_data = 0xBEEF from SETUP through HOLD, then Z; busy high for 9 clocks.
- Read: chip model drives 0x1234 while rd_n is low, addr = 1 → to_sw_data_in = 0x1234 after STROBE; block never drives otg_data.
- Back-to-back: second w_n edge 3 clocks after the first → dropped. The same edge after busy falls → a second strobe. At least 3 idle clocks separate the two strobes.
- Level hold: keep w_n low for 50 clocks → exactly one write strobe.
- Chip reset:
  - reset_n low for 2 clocks → otg_rst_n low exactly 16 clocks.
  - reset_n low for 40 clocks → otg_rst_n low until the clock after S.reset_n returns high.
  - Sync reset asserted mid-STROBE → all strobes high next clock, bus Z.
